bus_arbiter_rr: RTL



---
 rtl/bus_arbiter_rr.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// Two-master bus arbiter: grants ownership, sequences each transfer from strobe
// to slave ready, and terminates hung transfers with a forced ready plus error.
module bus_arbiter_rr #(
    parameter int POLICY         = 0,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic req_m0,
    input  logic req_m1,
    input  logic as_m0,
    input  logic as_m1,
    input  logic ready_i,
    output logic grant_m0,
    output logic grant_m1,
    output logic owner_o,
    output logic ready_o,
    output logic busy_o,
    output logic err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN      = 2'd1,
        XFER     = 2'd2,
        HANDOVER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             grant_m0_q, grant_m1_q, busy_q;

    logic req_own_s, req_oth_s, as_own_s;
    logic timeout_s, done_s, handover_ok_s;

    assign req_own_s = owner_q ? req_m1 : req_m0;
    assign req_oth_s = owner_q ? req_m0 : req_m1;
    assign as_own_s  = owner_q ? as_m1  : as_m0;

    assign timeout_s = (state_q == XFER) && (wd_q == WD_LAST);
    assign done_s    = ((state_q == XFER) && ready_i) || timeout_s;

    // Under fixed priority only master 1 may take the bus from a finishing master 0.
    assign handover_ok_s = req_oth_s && ((POLICY == 0) || (owner_q == 1'b0));

    // Next-state, owner selection and watchdog update.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wd_d         = wd_q;
        case (state_q)
            IDLE: begin
                if (req_m0 || req_m1) begin
                    state_d = OWN;
                    if (req_m0 && req_m1) begin
                        owner_d = (POLICY == 1) ? 1'b1 : ~last_owner_q;
                    end else begin
                        owner_d = req_m1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (as_own_s) begin
                    state_d = XFER;
                    wd_d    = '0;
                end else if (!req_own_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OWN;
                end
            end
            XFER: begin
                wd_d = wd_q + WD_ONE;
                if (done_s) begin
                    last_owner_d = owner_q;
                    if (handover_ok_s) begin
                        state_d = HANDOVER;
                    end else if (req_own_s) begin
                        state_d = OWN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            HANDOVER: begin
                if (req_oth_s) begin
                    state_d = OWN;
                    owner_d = ~owner_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, ownership history, watchdog and registered grant/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wd_q         <= '0;
            grant_m0_q   <= 1'b0;
            grant_m1_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wd_q         <= wd_d;
            grant_m0_q   <= ((state_d == OWN) || (state_d == XFER)) && (owner_d == 1'b0);
            grant_m1_q   <= ((state_d == OWN) || (state_d == XFER)) && (owner_d == 1'b1);
            busy_q       <= (state_d == XFER);
        end
    end

    // Ready and error must appear in the completion cycle itself, so they stay combinational.
    assign ready_o  = done_s;
    assign err_o    = timeout_s && !ready_i;
    assign grant_m0 = grant_m0_q;
    assign grant_m1 = grant_m1_q;
    assign busy_o   = busy_q;
    assign owner_o  = owner_q;

endmodule
